// File: rtl/enc_session_if.sv
// Request, datapath and response bundle for enc_session_arbiter.
// slave = arbiter side; master = requesters, datapath and response consumer.
interface enc_session_if #(
  parameter int DW = 64,
  parameter int PW = 32
);
  logic          a_valid, a_ready, b_valid, b_ready;
  logic [DW-1:0] a_r1, a_r2, a_c1, a_exp;
  logic [DW-1:0] b_r1, b_r2, b_c1, b_exp;
  logic [PW-1:0] a_p, b_p;

  logic [DW-1:0] dp_r1, dp_r2, dp_c1, dp_exp;
  logic [PW-1:0] dp_p;
  logic          dp_en;
  logic [DW-1:0] dp_c2;
  logic          dp_true;

  logic          rsp_valid, rsp_ready, rsp_id, rsp_ok;
  logic [DW-1:0] rsp_c2;

  modport slave (
    input  a_valid, a_r1, a_r2, a_c1, a_exp, a_p,
    input  b_valid, b_r1, b_r2, b_c1, b_exp, b_p,
    output a_ready, b_ready,
    output dp_r1, dp_r2, dp_c1, dp_exp, dp_p, dp_en,
    input  dp_c2, dp_true,
    output rsp_valid, rsp_id, rsp_c2, rsp_ok,
    input  rsp_ready
  );

  modport master (
    output a_valid, a_r1, a_r2, a_c1, a_exp, a_p,
    output b_valid, b_r1, b_r2, b_c1, b_exp, b_p,
    input  a_ready, b_ready,
    input  dp_r1, dp_r2, dp_c1, dp_exp, dp_p, dp_en,
    output dp_c2, dp_true,
    input  rsp_valid, rsp_id, rsp_c2, rsp_ok,
    output rsp_ready
  );
endinterface

// File: rtl/enc_session_arbiter.sv
// Shares one encryption/authentication datapath between requesters A and B.
// ENC_ARB_RR_EN selects round-robin arbitration; otherwise A has fixed priority.
module enc_session_arbiter #(
  parameter int DW      = 64,
  parameter int PW      = 32,
  parameter int ENC_LAT = 5
) (
  input  logic         clk,
  input  logic         rst,
  enc_session_if.slave bus
);
  localparam int            CW   = $clog2(ENC_LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(ENC_LAT);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, RESP = 2'd2} state_e;

  typedef struct packed {
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic [DW-1:0] c1;
    logic [DW-1:0] exp;
    logic [PW-1:0] p;
  } ops_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ops_t          ops_q, ops_d, req_a, req_b, req_sel;
  logic          id_q, id_d, ok_q, ok_d;
  logic [DW-1:0] c2_q, c2_d;
  logic          sel_b, open, hs;

  assign req_a   = {bus.a_r1, bus.a_r2, bus.a_c1, bus.a_exp, bus.a_p};
  assign req_b   = {bus.b_r1, bus.b_r2, bus.b_c1, bus.b_exp, bus.b_p};
  assign req_sel = sel_b ? req_b : req_a;

`ifdef ENC_ARB_RR_EN
  // prio_q = 1 means B is preferred when both requesters are valid.
  logic prio_q, prio_d;
  assign sel_b  = bus.b_valid & (~bus.a_valid | prio_q);
  assign prio_d = hs ? ~sel_b : prio_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prio_q <= 1'b0;
    else      prio_q <= prio_d;
  end
`else
  assign sel_b = bus.b_valid & ~bus.a_valid;
`endif

  // Readies are held low during reset even though state already reads IDLE.
  assign open        = rst & (state_q == IDLE);
  assign bus.a_ready = open & bus.a_valid & ~sel_b;
  assign bus.b_ready = open & sel_b;
  assign hs          = bus.a_ready | bus.b_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ops_d   = ops_q;
    id_d    = id_q;
    ok_d    = ok_q;
    c2_d    = c2_q;
    unique case (state_q)
      IDLE: if (hs) begin
        ops_d = req_sel;
        id_d  = sel_b;
        cnt_d = '0;
        // A zero modulus never reaches the datapath enable.
        if (req_sel.p == '0) begin
          state_d = RESP;
          ok_d    = 1'b0;
          c2_d    = '0;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST) begin
          ok_d    = bus.dp_true;
          c2_d    = bus.dp_true ? bus.dp_c2 : '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ops_q   <= '0;
      id_q    <= 1'b0;
      ok_q    <= 1'b0;
      c2_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ops_q   <= ops_d;
      id_q    <= id_d;
      ok_q    <= ok_d;
      c2_q    <= c2_d;
    end
  end

  assign bus.dp_r1     = ops_q.r1;
  assign bus.dp_r2     = ops_q.r2;
  assign bus.dp_c1     = ops_q.c1;
  assign bus.dp_exp    = ops_q.exp;
  assign bus.dp_p      = ops_q.p;
  assign bus.dp_en     = (state_q == RUN);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_ok    = ok_q;
  assign bus.rsp_c2    = c2_q;
endmodule

// File: tb/tb_enc_session_arbiter.sv
// Directed bench for enc_session_arbiter with a behavioural datapath model.
module tb_enc_session_arbiter;
  localparam int DW = 64, PW = 32, ENC_LAT = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  enc_session_if #(.DW(DW), .PW(PW)) bus ();

  enc_session_arbiter #(.DW(DW), .PW(PW), .ENC_LAT(ENC_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Datapath model: results settle after ENC_LAT enabled edges, cleared when enable drops.
  int            en_cnt = 0;
  logic [DW-1:0] k;
  logic          settled;

  always @(posedge clk) en_cnt <= bus.dp_en ? en_cnt + 1 : 0;

  always_comb begin
    k           = (bus.dp_p == '0) ? '0 : bus.dp_exp % {32'b0, bus.dp_p};
    settled     = bus.dp_en && (en_cnt >= ENC_LAT);
    bus.dp_true = settled && (bus.dp_r2 == (k ^ bus.dp_c1));
    bus.dp_c2   = settled ? (k ^ bus.dp_r1) : '0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic [63:0] r1, r2, c1, ex, input logic [31:0] p);
    bus.a_r1 = r1; bus.a_r2 = r2; bus.a_c1 = c1; bus.a_exp = ex; bus.a_p = p;
  endtask

  task automatic set_b(input logic [63:0] r1, r2, c1, ex, input logic [31:0] p);
    bus.b_r1 = r1; bus.b_r2 = r2; bus.b_c1 = c1; bus.b_exp = ex; bus.b_p = p;
  endtask

  // One isolated session: request, check latency/enable window, response, completion.
  task automatic session(input string tag, input bit use_b, input bit pz,
                         input logic exp_ok, input logic [63:0] exp_c2);
    if (use_b) bus.b_valid = 1'b1; else bus.a_valid = 1'b1;
    #1;
    chk({tag, "_ready"}, use_b ? bus.b_ready : bus.a_ready, 1'b1);
    chk({tag, "_other_ready"}, use_b ? bus.a_ready : bus.b_ready, 1'b0);
    tick();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    if (!pz) begin
      for (int i = 0; i < 6; i++) begin
        chk({tag, "_en"}, bus.dp_en, 1'b1);
        chk({tag, "_early_rsp"}, bus.rsp_valid, 1'b0);
        tick();
      end
    end
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 1'b1);
    chk({tag, "_en_off"}, bus.dp_en, 1'b0);
    chk({tag, "_rsp_id"}, bus.rsp_id, use_b);
    chk({tag, "_rsp_ok"}, bus.rsp_ok, exp_ok);
    chk({tag, "_rsp_c2"}, bus.rsp_c2, exp_c2);
    bus.rsp_ready = 1'b1;
    tick();
    chk({tag, "_done"}, bus.rsp_valid, 1'b0);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit seen = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid) begin
        seen = 1'b1;
        tick();
        break;
      end
      tick();
    end
    chk({tag, "_drain"}, seen, 1'b1);
    chk({tag, "_idle"}, bus.rsp_valid, 1'b0);
    bus.rsp_ready = 1'b0;
  endtask

  int acc_cyc[4];
  bit acc_id[4];
  int n;

  initial begin
    bus.a_valid = 1'b1; bus.b_valid = 1'b1; bus.rsp_ready = 1'b0;
    set_a(64'h10, 64'd7, 64'd5, 64'd23, 32'd7);
    set_b(64'h10, 64'd8, 64'd5, 64'd23, 32'd7);

    // Reset state, with both requesters already valid.
    #12;
    chk("rst_a_ready", bus.a_ready, 1'b0);
    chk("rst_b_ready", bus.b_ready, 1'b0);
    chk("rst_dp_en", bus.dp_en, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_id", bus.rsp_id, 1'b0);
    chk("rst_rsp_c2", bus.rsp_c2, 64'd0);
    chk("rst_rsp_ok", bus.rsp_ok, 1'b0);
    chk("rst_dp_p", bus.dp_p, 64'd0);
    chk("rst_dp_r1", bus.dp_r1, 64'd0);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // k = 23 mod 7 = 2; 2^5 = 7 = r2 -> pass; c2 = 2^0x10 = 0x12.
    session("a_pass", 1'b0, 1'b0, 1'b1, 64'h12);
    chk("a_dp_p", bus.dp_p, 64'd7);
    chk("a_dp_exp", bus.dp_exp, 64'd23);
    // r2 = 8 != 7 -> fail, c2 forced to 0.
    session("b_fail", 1'b1, 1'b0, 1'b0, 64'd0);
    chk("b_dp_r2", bus.dp_r2, 64'd8);
    // Zero modulus: straight to response, enable never raised.
    set_a(64'h10, 64'd7, 64'd5, 64'd23, 32'd0);
    session("a_pzero", 1'b0, 1'b1, 1'b0, 64'd0);
    chk("pzero_dp_p", bus.dp_p, 64'd0);

    // Contention with rsp_ready high.
    set_a(64'h10, 64'd7, 64'd5, 64'd23, 32'd7);
    bus.rsp_ready = 1'b1;
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    #1;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      if (bus.a_ready) begin acc_id[n] = 1'b0; acc_cyc[n] = c; n++; end
      else if (bus.b_ready) begin acc_id[n] = 1'b1; acc_cyc[n] = c; n++; end
      tick();
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    chk("arb_count", n, 4);
    for (int i = 0; i < n; i++) begin
`ifdef ENC_ARB_RR_EN
      chk("arb_id", acc_id[i], i[0]);
`else
      chk("arb_id", acc_id[i], 1'b0);
`endif
      if (i > 0) chk("arb_spacing", acc_cyc[i] - acc_cyc[i-1], 8);
    end
    drain("arb");

    // Backpressure: response held for 10 cycles while both requesters wait.
    bus.a_valid = 1'b1;
    #1;
    tick();
    bus.a_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid", bus.rsp_valid, 1'b1);
      chk("bp_hold_c2", bus.rsp_c2, 64'h12);
      chk("bp_hold_ok", bus.rsp_ok, 1'b1);
      chk("bp_hold_id", bus.rsp_id, 1'b0);
      chk("bp_a_ready", bus.a_ready, 1'b0);
      chk("bp_b_ready", bus.b_ready, 1'b0);
      chk("bp_dp_en", bus.dp_en, 1'b0);
      tick();
    end
    bus.b_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_release", bus.rsp_valid, 1'b0);
    chk("bp_reaccept", bus.a_ready, 1'b1);
    tick();
    chk("bp_next_en", bus.dp_en, 1'b1);
    bus.a_valid = 1'b0;
    drain("bp");

    // Reset pulsed during RUN at E0+3.
    bus.a_valid = 1'b1;
    #1;
    tick();
    bus.a_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("mid_running", bus.dp_en, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rst_en", bus.dp_en, 1'b0);
    chk("mid_rst_rsp", bus.rsp_valid, 1'b0);
    chk("mid_rst_ok", bus.rsp_ok, 1'b0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("mid_no_rsp", bus.rsp_valid, 1'b0);
      tick();
    end
    session("post_rst", 1'b0, 1'b0, 1'b1, 64'h12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
